// File: rtl/decode_pipe.sv
// Registered RV32I decode stage: register file, load-use detection and ID/EX register.
// Latency: 1 cycle from IF/ID inputs to ex_* outputs; register reads are combinational.
// Backpressure: ex_hold freezes ID/EX and raises stall; a load-use hazard inserts a bubble and raises stall.
module decode_pipe #(
  parameter int DATA_WIDTH = 32,
  parameter int PC_WIDTH   = 32,
  parameter int REG_WIDTH  = 5,
  parameter int BYPASS_EN  = 1,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_valid,
  input  logic [PC_WIDTH-1:0]   pc_out,
  input  logic [PC_WIDTH-1:0]   pc_plus4_out,
  input  logic [DATA_WIDTH-1:0] ins_out,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic [REG_WIDTH-1:0]  write_addr,
  input  logic                  write_enable,
  input  logic                  ex_hold,
  input  logic                  flush,
  output logic                  stall,
  output logic                  ex_valid,
  output logic [DATA_WIDTH-1:0] ex_read_data1,
  output logic [DATA_WIDTH-1:0] ex_read_data2,
  output logic [DATA_WIDTH-1:0] ex_imm,
  output logic [PC_WIDTH-1:0]   ex_pc,
  output logic [PC_WIDTH-1:0]   ex_pc_plus4,
  output logic [REG_WIDTH-1:0]  ex_rs1,
  output logic [REG_WIDTH-1:0]  ex_rs2,
  output logic [REG_WIDTH-1:0]  ex_rd,
  output logic [2:0]            ex_func3,
  output logic [2:0]            ex_branch_src,
  output logic [4:0]            ex_alu_control,
  output logic [1:0]            ex_alu_mux_src,
  output logic [1:0]            ex_result_src,
  output logic                  ex_mem_write,
  output logic                  ex_reg_write,
  output logic                  ex_branch_valid,
  output logic [CNT_WIDTH-1:0]  stall_cycles,
  output logic [DATA_WIDTH-1:0] a0
);
  localparam int DEPTH = 2 ** REG_WIDTH;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef struct packed {
    logic                  valid;
    logic [DATA_WIDTH-1:0] rd1;
    logic [DATA_WIDTH-1:0] rd2;
    logic [DATA_WIDTH-1:0] imm;
    logic [PC_WIDTH-1:0]   pc;
    logic [PC_WIDTH-1:0]   pc4;
    logic [REG_WIDTH-1:0]  rs1;
    logic [REG_WIDTH-1:0]  rs2;
    logic [REG_WIDTH-1:0]  rd;
    logic [2:0]            func3;
    logic [2:0]            branch_src;
    logic [4:0]            alu_control;
    logic [1:0]            alu_mux_src;
    logic [1:0]            result_src;
    logic                  mem_write;
    logic                  reg_write;
    logic                  branch_valid;
  } idex_t;

  logic [DATA_WIDTH-1:0] regs [DEPTH];
  idex_t                 idex_q;
  idex_t                 dec;
  logic [31:0]           ins;
  logic [31:0]           imm32;
  logic [31:0]           imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [REG_WIDTH-1:0]  rs1, rs2;
  logic [DATA_WIDTH-1:0] rd1, rd2;
  logic                  load_use;
  logic [CNT_WIDTH-1:0]  stall_cnt;

  assign ins   = ins_out[31:0];
  assign rs1   = REG_WIDTH'(ins[19:15]);
  assign rs2   = REG_WIDTH'(ins[24:20]);
  assign imm_i = {{20{ins[31]}}, ins[31:20]};
  assign imm_s = {{20{ins[31]}}, ins[31:25], ins[11:7]};
  assign imm_b = {{20{ins[31]}}, ins[7], ins[30:25], ins[11:8], 1'b0};
  assign imm_u = {ins[31:12], 12'h000};
  assign imm_j = {{12{ins[31]}}, ins[19:12], ins[20], ins[30:21], 1'b0};

  // Write-through: a WB write landing this cycle is seen by the decoding instruction.
  assign rd1 = (rs1 == '0) ? '0 :
               ((BYPASS_EN != 0) && write_enable && (write_addr == rs1)) ? write_data : regs[rs1];
  assign rd2 = (rs2 == '0) ? '0 :
               ((BYPASS_EN != 0) && write_enable && (write_addr == rs2)) ? write_data : regs[rs2];

  // rs fields are compared for every format, so U/J instructions may stall needlessly.
  assign load_use = if_valid && idex_q.valid && (idex_q.result_src == 2'b01) &&
                    (idex_q.rd != '0) && ((idex_q.rd == rs1) || (idex_q.rd == rs2));
  assign stall    = !rst && !flush && (ex_hold || load_use);

  always_comb begin
    dec       = '0;
    imm32     = '0;
    dec.valid = 1'b1;
    dec.rd1   = rd1;
    dec.rd2   = rd2;
    dec.pc    = pc_out;
    dec.pc4   = pc_plus4_out;
    dec.rs1   = rs1;
    dec.rs2   = rs2;
    dec.rd    = REG_WIDTH'(ins[11:7]);
    dec.func3 = ins[14:12];
    case (ins[6:0])
      OP_R: begin
        dec.reg_write   = 1'b1;
        dec.alu_control = {1'b0, ins[30], ins[14:12]};
      end
      OP_I: begin
        dec.reg_write   = 1'b1;
        dec.alu_mux_src = 2'b01;
        dec.alu_control = {1'b0, (ins[14:12] == 3'b101) & ins[30], ins[14:12]};
        imm32           = imm_i;
      end
      OP_LOAD: begin
        dec.reg_write   = 1'b1;
        dec.alu_mux_src = 2'b01;
        dec.result_src  = 2'b01;
        imm32           = imm_i;
      end
      OP_STORE: begin
        dec.mem_write   = 1'b1;
        dec.alu_mux_src = 2'b01;
        imm32           = imm_s;
      end
      OP_BRANCH: begin
        dec.branch_valid = 1'b1;
        dec.branch_src   = 3'b001;
        dec.alu_control  = 5'b01000;
        imm32            = imm_b;
      end
      OP_JAL: begin
        dec.reg_write    = 1'b1;
        dec.branch_valid = 1'b1;
        dec.branch_src   = 3'b010;
        dec.result_src   = 2'b10;
        imm32            = imm_j;
      end
      OP_JALR: begin
        dec.reg_write    = 1'b1;
        dec.branch_valid = 1'b1;
        dec.branch_src   = 3'b011;
        dec.result_src   = 2'b10;
        dec.alu_mux_src  = 2'b01;
        imm32            = imm_i;
      end
      OP_LUI: begin
        dec.reg_write  = 1'b1;
        dec.result_src = 2'b11;
        imm32          = imm_u;
      end
      OP_AUIPC: begin
        dec.reg_write   = 1'b1;
        dec.alu_mux_src = 2'b10;
        imm32           = imm_u;
      end
      default: ;
    endcase
    dec.imm = DATA_WIDTH'($signed(imm32));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idex_q    <= '0;
      stall_cnt <= '0;
    end else begin
      if (flush || (!ex_hold && (load_use || !if_valid))) begin
        idex_q <= '0;
      end else if (!ex_hold) begin
        idex_q <= dec;
      end
      if (stall && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + CNT_WIDTH'(1);
      end
    end
  end

  // WB writes land even while ID/EX is held; the held entry already latched its operands.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else if (write_enable && (write_addr != '0)) begin
      regs[write_addr] <= write_data;
    end
  end

  assign ex_valid        = idex_q.valid;
  assign ex_read_data1   = idex_q.rd1;
  assign ex_read_data2   = idex_q.rd2;
  assign ex_imm          = idex_q.imm;
  assign ex_pc           = idex_q.pc;
  assign ex_pc_plus4     = idex_q.pc4;
  assign ex_rs1          = idex_q.rs1;
  assign ex_rs2          = idex_q.rs2;
  assign ex_rd           = idex_q.rd;
  assign ex_func3        = idex_q.func3;
  assign ex_branch_src   = idex_q.branch_src;
  assign ex_alu_control  = idex_q.alu_control;
  assign ex_alu_mux_src  = idex_q.alu_mux_src;
  assign ex_result_src   = idex_q.result_src;
  assign ex_mem_write    = idex_q.mem_write;
  assign ex_reg_write    = idex_q.reg_write;
  assign ex_branch_valid = idex_q.branch_valid;
  assign stall_cycles    = stall_cnt;
  assign a0              = regs[REG_WIDTH'(10)];
endmodule

// File: tb/tb_decode_pipe.sv
// Bench for decode_pipe: directed scenarios plus randomized traffic against an ISA-level model.
module tb_decode_pipe;
  logic        clk = 1'b0;
  logic        rst, if_valid, write_enable, ex_hold, flush;
  logic [31:0] pc_out, pc_plus4_out, ins_out, write_data;
  logic [4:0]  write_addr;
  int          checks = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  // m_: default build, n_: BYPASS_EN=0, s_: CNT_WIDTH=2
  logic        m_stall, m_valid, m_mw, m_rw, m_bv;
  logic [31:0] m_rd1, m_rd2, m_imm, m_pc, m_pc4, m_a0;
  logic [4:0]  m_rs1, m_rs2, m_rd, m_aluc;
  logic [2:0]  m_f3, m_bsrc;
  logic [1:0]  m_amux, m_rsrc;
  logic [15:0] m_cnt;
  logic        n_stall, n_valid, n_mw, n_rw, n_bv;
  logic [31:0] n_rd1, n_rd2, n_imm, n_pc, n_pc4, n_a0;
  logic [4:0]  n_rs1, n_rs2, n_rd, n_aluc;
  logic [2:0]  n_f3, n_bsrc;
  logic [1:0]  n_amux, n_rsrc;
  logic [15:0] n_cnt;
  logic        s_stall, s_valid, s_mw, s_rw, s_bv;
  logic [31:0] s_rd1, s_rd2, s_imm, s_pc, s_pc4, s_a0;
  logic [4:0]  s_rs1, s_rs2, s_rd, s_aluc;
  logic [2:0]  s_f3, s_bsrc;
  logic [1:0]  s_amux, s_rsrc;
  logic [1:0]  s_cnt;

  decode_pipe u_m (
    .clk(clk), .rst(rst), .if_valid(if_valid), .pc_out(pc_out), .pc_plus4_out(pc_plus4_out),
    .ins_out(ins_out), .write_data(write_data), .write_addr(write_addr), .write_enable(write_enable),
    .ex_hold(ex_hold), .flush(flush), .stall(m_stall), .ex_valid(m_valid), .ex_read_data1(m_rd1),
    .ex_read_data2(m_rd2), .ex_imm(m_imm), .ex_pc(m_pc), .ex_pc_plus4(m_pc4), .ex_rs1(m_rs1),
    .ex_rs2(m_rs2), .ex_rd(m_rd), .ex_func3(m_f3), .ex_branch_src(m_bsrc), .ex_alu_control(m_aluc),
    .ex_alu_mux_src(m_amux), .ex_result_src(m_rsrc), .ex_mem_write(m_mw), .ex_reg_write(m_rw),
    .ex_branch_valid(m_bv), .stall_cycles(m_cnt), .a0(m_a0));

  decode_pipe #(.BYPASS_EN(0)) u_n (
    .clk(clk), .rst(rst), .if_valid(if_valid), .pc_out(pc_out), .pc_plus4_out(pc_plus4_out),
    .ins_out(ins_out), .write_data(write_data), .write_addr(write_addr), .write_enable(write_enable),
    .ex_hold(ex_hold), .flush(flush), .stall(n_stall), .ex_valid(n_valid), .ex_read_data1(n_rd1),
    .ex_read_data2(n_rd2), .ex_imm(n_imm), .ex_pc(n_pc), .ex_pc_plus4(n_pc4), .ex_rs1(n_rs1),
    .ex_rs2(n_rs2), .ex_rd(n_rd), .ex_func3(n_f3), .ex_branch_src(n_bsrc), .ex_alu_control(n_aluc),
    .ex_alu_mux_src(n_amux), .ex_result_src(n_rsrc), .ex_mem_write(n_mw), .ex_reg_write(n_rw),
    .ex_branch_valid(n_bv), .stall_cycles(n_cnt), .a0(n_a0));

  decode_pipe #(.CNT_WIDTH(2)) u_s (
    .clk(clk), .rst(rst), .if_valid(if_valid), .pc_out(pc_out), .pc_plus4_out(pc_plus4_out),
    .ins_out(ins_out), .write_data(write_data), .write_addr(write_addr), .write_enable(write_enable),
    .ex_hold(ex_hold), .flush(flush), .stall(s_stall), .ex_valid(s_valid), .ex_read_data1(s_rd1),
    .ex_read_data2(s_rd2), .ex_imm(s_imm), .ex_pc(s_pc), .ex_pc_plus4(s_pc4), .ex_rs1(s_rs1),
    .ex_rs2(s_rs2), .ex_rd(s_rd), .ex_func3(s_f3), .ex_branch_src(s_bsrc), .ex_alu_control(s_aluc),
    .ex_alu_mux_src(s_amux), .ex_result_src(s_rsrc), .ex_mem_write(s_mw), .ex_reg_write(s_rw),
    .ex_branch_valid(s_bv), .stall_cycles(s_cnt), .a0(s_a0));

  function automatic logic [31:0] enc_add(input logic [4:0] rd, input logic [4:0] r1, input logic [4:0] r2);
    return {7'b0000000, r2, r1, 3'b000, rd, 7'b0110011};
  endfunction
  function automatic logic [31:0] enc_addi(input logic [4:0] rd, input logic [4:0] r1, input logic [11:0] imm);
    return {imm, r1, 3'b000, rd, 7'b0010011};
  endfunction
  function automatic logic [31:0] enc_lw(input logic [4:0] rd, input logic [4:0] r1);
    return {12'h000, r1, 3'b010, rd, 7'b0000011};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    rst = 1'b0; if_valid = 1'b0; write_enable = 1'b0; ex_hold = 1'b0; flush = 1'b0;
  endtask

  task automatic apply_reset;
    idle();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic wb(input logic [4:0] a, input logic [31:0] d);
    write_enable = 1'b1; write_addr = a; write_data = d;
    tick();
    write_enable = 1'b0;
  endtask

  task automatic test_reset;
    idle();
    rst = 1'b1; if_valid = 1'b1; ex_hold = 1'b1; ins_out = enc_add(5'd3, 5'd1, 5'd2);
    #1;
    checks++; if (m_stall !== 1'b0) begin failures++; $display("FAIL reset_stall: got %0b want 0", m_stall); end
    tick(); tick();
    checks++; if (m_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %0b want 0", m_valid); end
    checks++; if (m_cnt !== 16'd0) begin failures++; $display("FAIL reset_cnt: got %0d want 0", m_cnt); end
    checks++; if ({m_rd, m_rd1, m_imm, m_rw} !== '0) begin failures++; $display("FAIL reset_fields: rd=%0d rd1=%0h imm=%0h rw=%0b want all 0", m_rd, m_rd1, m_imm, m_rw); end
    checks++; if (m_a0 !== 32'd0) begin failures++; $display("FAIL reset_a0: got %0h want 0", m_a0); end
    idle();
  endtask

  task automatic test_rtype;
    apply_reset();
    wb(5'd1, 32'd5); wb(5'd2, 32'd7);
    ins_out = enc_add(5'd3, 5'd1, 5'd2); if_valid = 1'b1; pc_out = 32'h100; pc_plus4_out = 32'h104;
    tick();
    if_valid = 1'b0;
    checks++; if (m_valid !== 1'b1) begin failures++; $display("FAIL rtype_valid: got %0b want 1", m_valid); end
    checks++; if (m_rd1 !== 32'd5) begin failures++; $display("FAIL rtype_rd1: got %0h want 5", m_rd1); end
    checks++; if (m_rd2 !== 32'd7) begin failures++; $display("FAIL rtype_rd2: got %0h want 7", m_rd2); end
    checks++; if (m_rd !== 5'd3) begin failures++; $display("FAIL rtype_rd: got %0d want 3", m_rd); end
    checks++; if ({m_rw, m_mw, m_bv, m_pc} !== {3'b100, 32'h100}) begin failures++; $display("FAIL rtype_ctrl: rw=%0b mw=%0b bv=%0b pc=%0h want 1 0 0 100", m_rw, m_mw, m_bv, m_pc); end
  endtask

  task automatic test_bypass;
    apply_reset();
    wb(5'd1, 32'd5); wb(5'd2, 32'd7);
    ins_out = enc_add(5'd3, 5'd1, 5'd2); if_valid = 1'b1;
    write_enable = 1'b1; write_addr = 5'd1; write_data = 32'hAA;
    tick();
    write_enable = 1'b0;
    checks++; if (m_rd1 !== 32'hAA) begin failures++; $display("FAIL bypass_on: got %0h want aa", m_rd1); end
    checks++; if (n_rd1 !== 32'd5) begin failures++; $display("FAIL bypass_off: got %0h want 5", n_rd1); end
    checks++; if (m_rd2 !== 32'd7) begin failures++; $display("FAIL bypass_rd2: got %0h want 7", m_rd2); end
    tick();
    checks++; if (n_rd1 !== 32'hAA) begin failures++; $display("FAIL bypass_off_later: got %0h want aa", n_rd1); end
    idle();
  endtask

  task automatic test_load_use;
    apply_reset();
    ins_out = enc_lw(5'd5, 5'd1); if_valid = 1'b1;
    tick();
    ins_out = enc_add(5'd6, 5'd5, 5'd1);
    #1;
    checks++; if (m_stall !== 1'b1) begin failures++; $display("FAIL lu_stall: got %0b want 1", m_stall); end
    tick();
    checks++; if ({m_valid, m_rw} !== 2'b00) begin failures++; $display("FAIL lu_bubble: valid=%0b rw=%0b want 0 0", m_valid, m_rw); end
    checks++; if (m_cnt !== 16'd1) begin failures++; $display("FAIL lu_cnt: got %0d want 1", m_cnt); end
    #1;
    checks++; if (m_stall !== 1'b0) begin failures++; $display("FAIL lu_release: got %0b want 0", m_stall); end
    tick();
    checks++; if ({m_valid, m_rd} !== {1'b1, 5'd6}) begin failures++; $display("FAIL lu_issue: valid=%0b rd=%0d want 1 6", m_valid, m_rd); end
    checks++; if (m_cnt !== 16'd1) begin failures++; $display("FAIL lu_cnt_after: got %0d want 1", m_cnt); end
    idle();
  endtask

  task automatic test_flush_priority;
    apply_reset();
    ins_out = enc_lw(5'd5, 5'd1); if_valid = 1'b1;
    tick();
    ins_out = enc_add(5'd6, 5'd5, 5'd1); flush = 1'b1;
    #1;
    checks++; if (m_stall !== 1'b0) begin failures++; $display("FAIL flush_stall: got %0b want 0", m_stall); end
    tick();
    checks++; if (m_valid !== 1'b0) begin failures++; $display("FAIL flush_bubble: got %0b want 0", m_valid); end
    checks++; if (m_cnt !== 16'd0) begin failures++; $display("FAIL flush_cnt: got %0d want 0", m_cnt); end
    idle();
  endtask

  task automatic test_hold;
    apply_reset();
    wb(5'd1, 32'd5); wb(5'd2, 32'd7);
    ins_out = enc_add(5'd3, 5'd1, 5'd2); if_valid = 1'b1;
    tick();
    ex_hold = 1'b1; ins_out = enc_addi(5'd9, 5'd1, 12'd1);
    write_enable = 1'b1; write_addr = 5'd1; write_data = 32'h33;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++; if (m_stall !== 1'b1) begin failures++; $display("FAIL hold_stall[%0d]: got %0b want 1", k, m_stall); end
      tick();
      write_enable = 1'b0;
      checks++; if ({m_valid, m_rd, m_rd1} !== {1'b1, 5'd3, 32'd5}) begin failures++; $display("FAIL hold_frozen[%0d]: valid=%0b rd=%0d rd1=%0h want 1 3 5", k, m_valid, m_rd, m_rd1); end
    end
    ex_hold = 1'b0;
    checks++; if (m_cnt !== 16'd3) begin failures++; $display("FAIL hold_cnt: got %0d want 3", m_cnt); end
    #1;
    checks++; if (m_stall !== 1'b0) begin failures++; $display("FAIL hold_release: got %0b want 0", m_stall); end
    tick();
    checks++; if ({m_rd, m_rd1, m_imm} !== {5'd9, 32'h33, 32'd1}) begin failures++; $display("FAIL hold_next: rd=%0d rd1=%0h imm=%0h want 9 33 1", m_rd, m_rd1, m_imm); end
    idle();
  endtask

  task automatic test_saturate_and_reset;
    apply_reset();
    ex_hold = 1'b1;
    repeat (5) tick();
    checks++; if (m_cnt !== 16'd5) begin failures++; $display("FAIL sat_wide: got %0d want 5", m_cnt); end
    checks++; if (s_cnt !== 2'd3) begin failures++; $display("FAIL sat_narrow: got %0d want 3", s_cnt); end
    rst = 1'b1;
    #1;
    checks++; if (m_stall !== 1'b0) begin failures++; $display("FAIL rst_mid_stall: got %0b want 0", m_stall); end
    tick();
    checks++; if (m_cnt !== 16'd0) begin failures++; $display("FAIL rst_mid_cnt: got %0d want 0", m_cnt); end
    rst = 1'b0; ex_hold = 1'b0; ins_out = enc_add(5'd3, 5'd1, 5'd2); if_valid = 1'b1;
    tick();
    checks++; if ({m_valid, m_rd} !== {1'b1, 5'd3}) begin failures++; $display("FAIL rst_mid_decode: valid=%0b rd=%0d want 1 3", m_valid, m_rd); end
    idle();
  endtask

  task automatic test_x0_and_a0;
    apply_reset();
    wb(5'd0, 32'h1234);
    ins_out = enc_add(5'd3, 5'd0, 5'd0); if_valid = 1'b1;
    write_enable = 1'b1; write_addr = 5'd0; write_data = 32'hFFFF;
    tick();
    write_enable = 1'b0;
    checks++; if ({m_rd1, m_rd2} !== 64'd0) begin failures++; $display("FAIL x0_read: rd1=%0h rd2=%0h want 0 0", m_rd1, m_rd2); end
    wb(5'd10, 32'h5A5A);
    checks++; if (m_a0 !== 32'h5A5A) begin failures++; $display("FAIL a0_value: got %0h want 5a5a", m_a0); end
    idle();
  endtask

  task automatic test_random;
    logic [6:0]  ops [9];
    logic [31:0] mregs [32];
    logic        e_valid, e_rw, e_mw, e_bv, e_load, e_chk, lu, exp_stall;
    logic [31:0] e_rd1, e_rd2, e_nd1, e_nd2, e_imm, e_pc, e_pc4;
    logic [4:0]  e_rd, e_rs1, e_rs2, r1, r2;
    int          e_cnt, e_scnt;
    ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
            7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111};
    apply_reset();
    for (int i = 0; i < 32; i++) mregs[i] = '0;
    {e_valid, e_rw, e_mw, e_bv, e_load, e_chk} = '0;
    {e_rd1, e_rd2, e_nd1, e_nd2, e_imm, e_pc, e_pc4, e_rd, e_rs1, e_rs2} = '0;
    e_cnt = 0; e_scnt = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      rst          = ($urandom_range(0, 59) == 0);
      if_valid     = ($urandom_range(0, 3) != 0);
      ex_hold      = ($urandom_range(0, 7) == 0);
      flush        = ($urandom_range(0, 11) == 0);
      write_enable = ($urandom_range(0, 1) == 1);
      write_addr   = 5'($urandom_range(0, 7));
      write_data   = $urandom;
      pc_out       = $urandom;
      pc_plus4_out = pc_out + 32'd4;
      ins_out      = $urandom;
      ins_out[6:0]   = ops[$urandom_range(0, 8)];
      ins_out[11:7]  = 5'($urandom_range(0, 7));
      ins_out[19:15] = 5'($urandom_range(0, 7));
      ins_out[24:20] = 5'($urandom_range(0, 7));
      r1 = ins_out[19:15];
      r2 = ins_out[24:20];
      #1;
      lu = if_valid && e_valid && e_load && (e_rd != 0) && (e_rd == r1 || e_rd == r2);
      exp_stall = !rst && !flush && (ex_hold || lu);
      checks++; if (m_stall !== exp_stall) begin failures++; $display("FAIL rnd_stall cyc%0d: got %0b want %0b", cyc, m_stall, exp_stall); end
      if (rst) begin
        for (int i = 0; i < 32; i++) mregs[i] = '0;
        {e_valid, e_rw, e_mw, e_bv, e_load, e_chk} = '0;
        e_cnt = 0; e_scnt = 0;
      end else begin
        if (flush || (!ex_hold && (lu || !if_valid))) begin
          {e_valid, e_rw, e_mw, e_bv, e_load, e_chk} = '0;
        end else if (!ex_hold) begin
          e_valid = 1'b1;
          e_nd1 = (r1 == 0) ? 32'd0 : mregs[r1];
          e_nd2 = (r2 == 0) ? 32'd0 : mregs[r2];
          e_rd1 = (r1 != 0 && write_enable && write_addr == r1) ? write_data : e_nd1;
          e_rd2 = (r2 != 0 && write_enable && write_addr == r2) ? write_data : e_nd2;
          e_rd = ins_out[11:7]; e_rs1 = r1; e_rs2 = r2; e_pc = pc_out; e_pc4 = pc_plus4_out;
          {e_rw, e_mw, e_bv, e_load, e_chk} = '0;
          case (ins_out[6:0])
            7'b0110011: e_rw = 1'b1;
            7'b0010011: begin e_rw = 1'b1; e_chk = 1'b1; e_imm = 32'($signed(ins_out[31:20])); end
            7'b0000011: begin e_rw = 1'b1; e_load = 1'b1; e_chk = 1'b1; e_imm = 32'($signed(ins_out[31:20])); end
            7'b0100011: begin e_mw = 1'b1; e_chk = 1'b1; e_imm = 32'($signed({ins_out[31:25], ins_out[11:7]})); end
            7'b1100011: begin e_bv = 1'b1; e_chk = 1'b1; e_imm = 32'($signed({ins_out[31], ins_out[7], ins_out[30:25], ins_out[11:8], 1'b0})); end
            7'b1101111: begin e_rw = 1'b1; e_bv = 1'b1; e_chk = 1'b1; e_imm = 32'($signed({ins_out[31], ins_out[19:12], ins_out[20], ins_out[30:21], 1'b0})); end
            7'b1100111: begin e_rw = 1'b1; e_bv = 1'b1; e_chk = 1'b1; e_imm = 32'($signed(ins_out[31:20])); end
            default:    begin e_rw = 1'b1; e_chk = 1'b1; e_imm = ins_out & 32'hFFFFF000; end
          endcase
        end
        if (write_enable && write_addr != 0) mregs[write_addr] = write_data;
        if (exp_stall) begin
          if (e_cnt < 65535) e_cnt++;
          if (e_scnt < 3) e_scnt++;
        end
      end
      tick();
      checks++; if ({m_valid, m_rw, m_mw, m_bv, m_rsrc == 2'b01} !== {e_valid, e_rw, e_mw, e_bv, e_load}) begin
        failures++; $display("FAIL rnd_ctrl cyc%0d: got v/rw/mw/bv/ld=%05b want %05b", cyc, {m_valid, m_rw, m_mw, m_bv, m_rsrc == 2'b01}, {e_valid, e_rw, e_mw, e_bv, e_load}); end
      if (e_valid) begin
        checks++; if ({m_rd1, m_rd2} !== {e_rd1, e_rd2}) begin failures++; $display("FAIL rnd_data cyc%0d: got %0h %0h want %0h %0h", cyc, m_rd1, m_rd2, e_rd1, e_rd2); end
        checks++; if ({n_rd1, n_rd2} !== {e_nd1, e_nd2}) begin failures++; $display("FAIL rnd_data_nobyp cyc%0d: got %0h %0h want %0h %0h", cyc, n_rd1, n_rd2, e_nd1, e_nd2); end
        checks++; if ({m_rd, m_rs1, m_rs2, m_pc, m_pc4} !== {e_rd, e_rs1, e_rs2, e_pc, e_pc4}) begin failures++; $display("FAIL rnd_fields cyc%0d: rd/rs1/rs2=%0d/%0d/%0d pc=%0h want %0d/%0d/%0d %0h", cyc, m_rd, m_rs1, m_rs2, m_pc, e_rd, e_rs1, e_rs2, e_pc); end
        if (e_chk) begin
          checks++; if (m_imm !== e_imm) begin failures++; $display("FAIL rnd_imm cyc%0d: got %0h want %0h", cyc, m_imm, e_imm); end
        end
      end
      checks++; if ({m_cnt, s_cnt} !== {16'(e_cnt), 2'(e_scnt)}) begin failures++; $display("FAIL rnd_cnt cyc%0d: got %0d/%0d want %0d/%0d", cyc, m_cnt, s_cnt, e_cnt, e_scnt); end
      checks++; if (m_a0 !== mregs[10]) begin failures++; $display("FAIL rnd_a0 cyc%0d: got %0h want %0h", cyc, m_a0, mregs[10]); end
    end
    idle();
  endtask

  initial begin
    rst = 1'b1; if_valid = 1'b0; write_enable = 1'b0; ex_hold = 1'b0; flush = 1'b0;
    pc_out = '0; pc_plus4_out = 32'd4; ins_out = '0; write_data = '0; write_addr = '0;
    test_reset();
    test_rtype();
    test_bypass();
    test_load_use();
    test_flush_priority();
    test_hold();
    test_saturate_and_reset();
    test_x0_and_a0();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
